// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU bus: byte RAM with programmable read/write
// wait states, a write-protected window, an open-bus region and a debug backdoor.
module cpu_bus_responder #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    MEM_AW       = 12,
  parameter int                    READ_WAIT    = 2,
  parameter int                    WRITE_WAIT   = 1,
  parameter logic [ADDR_WIDTH-1:0] WP_LO        = 16'h0F00,
  parameter logic [ADDR_WIDTH-1:0] WP_HI        = 16'h0FFF,
  parameter logic [DATA_WIDTH-1:0] OPEN_BUS_VAL = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  cpu_enable,
  output logic                  err_wp,
  output logic                  err_oob,
  input  logic                  dbg_we,
  input  logic [MEM_AW-1:0]     dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata
);

  localparam int         DEPTH  = 1 << MEM_AW;
  localparam logic       OP_RD  = 1'b0;
  localparam logic       OP_WR  = 1'b1;
  localparam logic [3:0] RD_CNT = 4'(READ_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_OPEN} src_t;

  state_t                state_reg, state_next;
  logic                  op, op_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_next;
  logic [3:0]            cnt, cnt_next;
  logic [3:0]            load_cnt;

  // Operands of the access performed on the edge entering RESP
  logic                  do_access;
  logic                  acc_op;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_in_ram;
  logic                  acc_in_wp;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  src_t                  src_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op        <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
    end else begin
      state_reg <= state_next;
      op        <= op_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      cnt       <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    cnt_next   = cnt;
    load_cnt   = which_rdwr ? WR_CNT : RD_CNT;
    do_access  = 1'b0;
    acc_op     = op;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    cpu_enable = 1'b1;
    case (state_reg)
      IDLE: begin
        if (req_rdwr) begin
          cpu_enable = 1'b0;
          op_next    = which_rdwr;
          addr_next  = addr;
          wdata_next = data_out;
          cnt_next   = load_cnt;
          if (load_cnt == 4'd0) begin
            // Zero wait states: access straight from the live bus inputs
            do_access  = 1'b1;
            acc_op     = which_rdwr;
            acc_addr   = addr;
            acc_wdata  = data_out;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cpu_enable = 1'b0;
        cnt_next   = cnt - 4'd1;
        if (cnt == 4'd1) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      cpu_enable = 1'b1;
    end
  end

  assign acc_in_ram = ((acc_addr >> MEM_AW) == '0);
  assign acc_in_wp  = (acc_addr >= WP_LO) && (acc_addr <= WP_HI);

  // One write port shared by CPU writes and the backdoor; they never coincide
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = dbg_addr;
    mem_wdata = dbg_wdata;
    if (do_access && acc_op == OP_WR && !acc_in_wp && acc_in_ram) begin
      mem_we    = 1'b1;
      mem_waddr = acc_addr[MEM_AW-1:0];
      mem_wdata = acc_wdata;
    end else if (dbg_we && state_reg == IDLE && !req_rdwr) begin
      mem_we = 1'b1;
    end
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  assign rd_en = do_access && acc_op == OP_RD && acc_in_ram && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      rd_data <= mem[acc_addr[MEM_AW-1:0]];
    end
  end

  // Track where the last read result came from so the RAM output stays reset-free
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg <= SRC_ZERO;
      err_wp  <= 1'b0;
      err_oob <= 1'b0;
    end else begin
      err_wp  <= do_access && acc_op == OP_WR && acc_in_wp;
      err_oob <= do_access && acc_op == OP_WR && !acc_in_wp && !acc_in_ram;
      if (do_access && acc_op == OP_RD) begin
        src_reg <= acc_in_ram ? SRC_RAM : SRC_OPEN;
      end
    end
  end

  always_comb begin
    case (src_reg)
      SRC_RAM:  data_in = rd_data;
      SRC_OPEN: data_in = OPEN_BUS_VAL;
      default:  data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized bench for cpu_bus_responder: two instances with different wait
// settings, checked every cycle against a transaction-level model.
module tb_cpu_bus_responder;

  localparam int RW0 = 2;
  localparam int WW0 = 1;
  localparam int RW1 = 0;
  localparam int WW1 = 3;

  logic        clk;
  logic        in_rst;
  logic        in_req  [2];
  logic        in_wh   [2];
  logic [15:0] in_addr [2];
  logic [7:0]  in_wd   [2];
  logic        in_dwe  [2];
  logic [11:0] in_da   [2];
  logic [7:0]  in_dd   [2];
  logic [7:0]  data_o  [2];
  logic        en_o    [2];
  logic        wp_o    [2];
  logic        oob_o   [2];

  // Model state
  logic [7:0]  mem [2][4096];
  logic [7:0]  last [2];
  logic [1:0]  exp_en, exp_wp, exp_oob;
  logic [7:0]  exp_data [2];
  bit          exp_live;
  int          n_cmp = 0;
  int          n_bad = 0;

  cpu_bus_responder #(.READ_WAIT(RW0), .WRITE_WAIT(WW0)) dut_a (
    .clk(clk), .rst(in_rst), .req_rdwr(in_req[0]), .which_rdwr(in_wh[0]),
    .addr(in_addr[0]), .data_out(in_wd[0]), .data_in(data_o[0]),
    .cpu_enable(en_o[0]), .err_wp(wp_o[0]), .err_oob(oob_o[0]),
    .dbg_we(in_dwe[0]), .dbg_addr(in_da[0]), .dbg_wdata(in_dd[0])
  );

  cpu_bus_responder #(.READ_WAIT(RW1), .WRITE_WAIT(WW1)) dut_b (
    .clk(clk), .rst(in_rst), .req_rdwr(in_req[1]), .which_rdwr(in_wh[1]),
    .addr(in_addr[1]), .data_out(in_wd[1]), .data_in(data_o[1]),
    .cpu_enable(en_o[1]), .err_wp(wp_o[1]), .err_oob(oob_o[1]),
    .dbg_we(in_dwe[1]), .dbg_addr(in_da[1]), .dbg_wdata(in_dd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int rwait(int d);
    return (d == 0) ? RW0 : RW1;
  endfunction

  function automatic int wwait(int d);
    return (d == 0) ? WW0 : WW1;
  endfunction

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 16'($urandom_range(0, 63));
    else if (r < 8) return 16'($urandom_range(16'h0EF8, 16'h1008));
    else return 16'($urandom);
  endfunction

  task automatic check(string nm, int d, logic [7:0] act, logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, d, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_live) begin
      for (int d = 0; d < 2; d++) begin
        check("cpu_enable", d, 8'(en_o[d]), 8'(exp_en[d]));
        check("err_wp", d, 8'(wp_o[d]), 8'(exp_wp[d]));
        check("err_oob", d, 8'(oob_o[d]), 8'(exp_oob[d]));
        check("data_in", d, data_o[d], exp_data[d]);
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    in_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_req[d]  = 1'b0;
      in_wh[d]   = 1'b0;
      in_addr[d] = '0;
      in_wd[d]   = '0;
      in_dwe[d]  = 1'b0;
      in_da[d]   = '0;
      in_dd[d]   = '0;
    end
  endtask

  task automatic end_cycle(logic [1:0] en, logic [1:0] wp, logic [1:0] oob);
    exp_en      = en;
    exp_wp      = wp;
    exp_oob     = oob;
    exp_data[0] = last[0];
    exp_data[1] = last[1];
    exp_live    = 1'b1;
  endtask

  task automatic garbage(int d);
    in_req[d]  = 1'($urandom);
    in_wh[d]   = 1'($urandom);
    in_addr[d] = 16'($urandom);
    in_wd[d]   = 8'($urandom);
    in_dwe[d]  = 1'($urandom);
    in_da[d]   = 12'($urandom);
    in_dd[d]   = 8'($urandom);
  endtask

  task automatic reset_cycles(int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      in_rst    = 1'b1;
      in_req[0] = 1'($urandom);
      in_req[1] = 1'($urandom);
      end_cycle(2'b11, 2'b00, 2'b00);
      last[0] = 8'h00;
      last[1] = 8'h00;
    end
  endtask

  task automatic backdoor(int d, logic [11:0] a, logic [7:0] v);
    begin_cycle();
    in_dwe[d] = 1'b1;
    in_da[d]  = a;
    in_dd[d]  = v;
    mem[d][a] = v;
    end_cycle(2'b11, 2'b00, 2'b00);
  endtask

  task automatic idle_random();
    begin_cycle();
    for (int d = 0; d < 2; d++) begin
      in_dwe[d] = 1'($urandom);
      in_da[d]  = 12'($urandom);
      in_dd[d]  = 8'($urandom);
      if (in_dwe[d]) mem[d][in_da[d]] = in_dd[d];
    end
    end_cycle(2'b11, 2'b00, 2'b00);
  endtask

  // One CPU access: request cycle, wait cycles, then the single RESP cycle
  task automatic access(int d, bit wr, logic [15:0] a, logic [7:0] wd, int abort_at, int lit);
    int         w;
    logic [1:0] en_v, wp_v, oob_v;
    w = wr ? wwait(d) : rwait(d);
    for (int i = 0; i <= w; i++) begin
      begin_cycle();
      if (i == 0) begin
        in_req[d]  = 1'b1;
        in_wh[d]   = wr;
        in_addr[d] = a;
        in_wd[d]   = wd;
        in_dwe[d]  = 1'($urandom);
        in_da[d]   = 12'($urandom);
        in_dd[d]   = 8'($urandom);
      end else begin
        garbage(d);
      end
      if (i == abort_at) begin
        in_rst    = 1'b1;
        in_dwe[d] = 1'b0;
        end_cycle(2'b11, 2'b00, 2'b00);
        last[0] = 8'h00;
        last[1] = 8'h00;
        $display("txn dut%0d %s addr=%h wdata=%h aborted by reset in cycle %0d",
                 d, wr ? "wr" : "rd", a, wd, i);
        return;
      end
      en_v    = 2'b11;
      en_v[d] = 1'b0;
      end_cycle(en_v, 2'b00, 2'b00);
    end
    begin_cycle();
    garbage(d);
    wp_v  = 2'b00;
    oob_v = 2'b00;
    if (!wr) begin
      last[d] = (a < 16'h1000) ? mem[d][a[11:0]] : 8'hFF;
    end else if (a >= 16'h0F00 && a <= 16'h0FFF) begin
      wp_v[d] = 1'b1;
    end else if (a >= 16'h1000) begin
      oob_v[d] = 1'b1;
    end else begin
      mem[d][a[11:0]] = wd;
    end
    end_cycle(2'b11, wp_v, oob_v);
    $display("txn dut%0d %s addr=%h wdata=%h -> data_in=%h err_wp=%0d err_oob=%0d",
             d, wr ? "wr" : "rd", a, wd, last[d], wp_v[d], oob_v[d]);
    if (lit >= 0) begin
      @(negedge clk);
      check("lit_data", d, data_o[d], 8'(lit));
    end
  endtask

  int  d_r, r_r, ab_r;
  bit  wr_r;

  initial begin
    in_rst   = 1'b1;
    exp_live = 1'b0;
    last[0]  = 8'h00;
    last[1]  = 8'h00;
    for (int d = 0; d < 2; d++) begin
      in_req[d] = 1'b0; in_wh[d] = 1'b0; in_addr[d] = '0; in_wd[d] = '0;
      in_dwe[d] = 1'b0; in_da[d] = '0;   in_dd[d] = '0;
    end
    reset_cycles(3);

    for (int i = 0; i < 4096; i++) begin
      begin_cycle();
      for (int d = 0; d < 2; d++) begin
        in_dwe[d] = 1'b1;
        in_da[d]  = 12'(i);
        in_dd[d]  = 8'($urandom);
        mem[d][i] = in_dd[d];
      end
      end_cycle(2'b11, 2'b00, 2'b00);
    end

    // Directed scenarios on the 2/1 wait-state instance
    backdoor(0, 12'h010, 8'hA5);
    idle_random();
    access(0, 1'b0, 16'h0010, 8'h00, -1, 8'hA5);
    access(0, 1'b1, 16'h0020, 8'h3C, -1, -1);
    access(0, 1'b0, 16'h0020, 8'h00, -1, 8'h3C);
    backdoor(0, 12'hF10, 8'h11);
    access(0, 1'b1, 16'h0F10, 8'h77, -1, -1);
    access(0, 1'b0, 16'h0F10, 8'h00, -1, 8'h11);
    backdoor(0, 12'h000, 8'h42);
    access(0, 1'b0, 16'h8000, 8'h00, -1, 8'hFF);
    access(0, 1'b1, 16'h8000, 8'h55, -1, -1);
    access(0, 1'b0, 16'h0000, 8'h00, -1, 8'h42);

    // Directed scenarios on the 0/3 wait-state instance
    backdoor(1, 12'h010, 8'hA5);
    backdoor(1, 12'h011, 8'h5A);
    access(1, 1'b0, 16'h0010, 8'h00, -1, 8'hA5);
    access(1, 1'b0, 16'h0011, 8'h00, -1, 8'h5A);
    backdoor(1, 12'h030, 8'h66);
    access(1, 1'b1, 16'h0030, 8'h99, 2, -1);
    idle_random();
    access(1, 1'b0, 16'h0030, 8'h00, -1, 8'h66);

    for (int k = 0; k < 400; k++) begin
      d_r = $urandom_range(0, 1);
      r_r = $urandom_range(0, 29);
      if (r_r < 6) begin
        idle_random();
      end else if (r_r < 17) begin
        access(d_r, 1'b0, pick_addr(), 8'h00, -1, -1);
      end else if (r_r < 28) begin
        access(d_r, 1'b1, pick_addr(), 8'($urandom), -1, -1);
      end else begin
        wr_r = 1'($urandom);
        ab_r = $urandom_range(0, wr_r ? wwait(d_r) : rwait(d_r));
        access(d_r, wr_r, pick_addr(), 8'($urandom), ab_r, -1);
      end
    end

    begin_cycle();
    end_cycle(2'b11, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
